// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp patterns for the two-road intersection controller.
// The state values double as the debug phase code.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_AR    = 3'd0,
        ST_NS_G  = 3'd1,
        ST_NS_Y  = 3'd2,
        ST_EW_G  = 3'd3,
        ST_EW_Y  = 3'd4,
        ST_EMERG = 3'd5
    } state_t;

    // Lamp bundles are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle timing tick every TICK_DIV clocks.
// It never restarts on phase changes, so phase timing is quantised to the tick grid.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_controller_param.sv
// Two-road intersection controller: NS main road, EW side road with demand sensing,
// all-red clearance, latched pedestrian walk requests and emergency pre-emption.
module traffic_light_controller_param
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 8,
    parameter int GREEN_NS = 4,
    parameter int GREEN_EW = 3,
    parameter int YELLOW   = 2,
    parameter int ALLRED   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_ew,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       emergency,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] T_GNS = CNT_W'(GREEN_NS - 1);
    localparam logic [CNT_W-1:0] T_GEW = CNT_W'(GREEN_EW - 1);
    localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALLRED - 1);

    state_t           state, state_n;
    state_t           target, target_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             tick;
    logic             ped_ns_l, ped_ew_l;
    logic             walk_ns_r, walk_ew_r;
    logic             ew_demand;
    logic             enter_ns_g, enter_ew_g;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign ew_demand = sensor_ew | ped_ew_l;

    // Green pre-emption and EMERG release act on the clock edge, not the tick.
    always_comb begin
        state_n  = state;
        target_n = target;
        timer_n  = timer;
        if (emergency && state == ST_NS_G) begin
            state_n = ST_NS_Y;
            timer_n = T_YEL;
        end else if (emergency && state == ST_EW_G) begin
            state_n = ST_EW_Y;
            timer_n = T_YEL;
        end else if (state == ST_EMERG) begin
            if (!emergency) begin
                state_n  = ST_AR;
                target_n = ST_NS_G;
                timer_n  = T_AR;
            end
        end else if (tick) begin
            if (timer != '0) begin
                timer_n = timer - 1'b1;
            end else begin
                case (state)
                    ST_AR: begin
                        if (emergency) begin
                            state_n = ST_EMERG;
                            timer_n = '0;
                        end else if (target == ST_EW_G) begin
                            state_n = ST_EW_G;
                            timer_n = T_GEW;
                        end else begin
                            state_n = ST_NS_G;
                            timer_n = T_GNS;
                        end
                    end
                    ST_NS_G: begin
                        if (ew_demand) begin
                            state_n = ST_NS_Y;
                            timer_n = T_YEL;
                        end
                    end
                    ST_NS_Y: begin
                        state_n  = ST_AR;
                        target_n = ST_EW_G;
                        timer_n  = T_AR;
                    end
                    ST_EW_G: begin
                        state_n = ST_EW_Y;
                        timer_n = T_YEL;
                    end
                    ST_EW_Y: begin
                        state_n  = ST_AR;
                        target_n = ST_NS_G;
                        timer_n  = T_AR;
                    end
                    default: begin
                        state_n  = ST_AR;
                        target_n = ST_NS_G;
                        timer_n  = T_AR;
                    end
                endcase
            end
        end
    end

    assign enter_ns_g = (state_n == ST_NS_G) && (state != ST_NS_G);
    assign enter_ew_g = (state_n == ST_EW_G) && (state != ST_EW_G);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_AR;
            target <= ST_NS_G;
            timer  <= T_AR;
        end else begin
            state  <= state_n;
            target <= target_n;
            timer  <= timer_n;
        end
    end

    // A press coinciding with green entry is folded into that green's walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_ns_l  <= 1'b0;
            ped_ew_l  <= 1'b0;
            walk_ns_r <= 1'b0;
            walk_ew_r <= 1'b0;
        end else begin
            if (enter_ns_g) begin
                walk_ns_r <= ped_ns_l | ped_req_ns;
                ped_ns_l  <= 1'b0;
            end else begin
                walk_ns_r <= walk_ns_r && (state_n == ST_NS_G);
                ped_ns_l  <= ped_ns_l | ped_req_ns;
            end
            if (enter_ew_g) begin
                walk_ew_r <= ped_ew_l | ped_req_ew;
                ped_ew_l  <= 1'b0;
            end else begin
                walk_ew_r <= walk_ew_r && (state_n == ST_EW_G);
                ped_ew_l  <= ped_ew_l | ped_req_ew;
            end
        end
    end

    always_comb begin
        NS = LAMP_RED;
        EW = LAMP_RED;
        case (state)
            ST_NS_G: NS = LAMP_GRN;
            ST_NS_Y: NS = LAMP_YEL;
            ST_EW_G: EW = LAMP_GRN;
            ST_EW_Y: EW = LAMP_YEL;
            default: ;
        endcase
    end

    assign walk_ns = walk_ns_r && (state == ST_NS_G);
    assign walk_ew = walk_ew_r && (state == ST_EW_G);
    assign phase   = state;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Scoreboard bench: stimulus queues the expected per-cycle phase/lamps/walks,
// a negedge monitor pops and compares; a second TICK_DIV=4 instance checks tick scaling.
module tb_traffic_light_controller_param;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sensor_ew = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0, emergency = 1'b0;
    logic [2:0] NS, EW, phase;
    logic       walk_ns, walk_ew;

    logic       reset4 = 1'b0;
    logic [2:0] NS4, EW4, phase4;
    logic       walk_ns4, walk_ew4;

    always #5 clk = ~clk;

    traffic_light_controller_param dut (
        .clk(clk), .reset(reset), .sensor_ew(sensor_ew), .ped_req_ns(ped_req_ns),
        .ped_req_ew(ped_req_ew), .emergency(emergency), .NS(NS), .EW(EW),
        .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase)
    );

    traffic_light_controller_param #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset4), .sensor_ew(1'b1), .ped_req_ns(1'b0),
        .ped_req_ew(1'b0), .emergency(1'b0), .NS(NS4), .EW(EW4),
        .walk_ns(walk_ns4), .walk_ew(walk_ew4), .phase(phase4)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wns;
        logic       wew;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0, step = 0;

    function automatic exp_t mk(input int ph, input logic wns, input logic wew);
        exp_t e;
        e.ph  = 3'(ph);
        e.ns  = 3'b100;
        e.ew  = 3'b100;
        case (ph)
            1: e.ns = 3'b001;
            2: e.ns = 3'b010;
            3: e.ew = 3'b001;
            4: e.ew = 3'b010;
            default: ;
        endcase
        e.wns = wns;
        e.wew = wew;
        return e;
    endfunction

    // Monitor
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                step++;
                checks++;
                if ({phase, NS, EW, walk_ns, walk_ew} !== e) begin
                    errors++;
                    $display("FAIL step%0d: got phase=%0d NS=%b EW=%b walk=%b%b, expected phase=%0d NS=%b EW=%b walk=%b%b",
                             step, phase, NS, EW, walk_ns, walk_ew, e.ph, e.ns, e.ew, e.wns, e.wew);
                end
                checks++;
                if (NS !== 3'b100 && EW !== 3'b100) begin
                    errors++;
                    $display("FAIL overlap step%0d: got NS=%b EW=%b, expected one road red", step, NS, EW);
                end
            end
        end
    end

    task automatic cyc(input int ph, input logic wns, input logic wew);
        q.push_back(mk(ph, wns, wew));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ph, input int n, input logic wns = 1'b0, input logic wew = 1'b0);
        for (int i = 0; i < n; i++) cyc(ph, wns, wew);
    endtask

    task automatic ew_service(input logic wew);
        run(2, 2); run(0, 1); run(3, 3, 1'b0, wew); run(4, 2); run(0, 1);
    endtask

    initial begin : stim
        int rph[$];
        int rlen[$];
        int sum;
        logic ovl;
        int exp_ph[8];

        @(posedge clk); #1;
        run(0, 2);                          // held in reset
        reset = 1'b1; sensor_ew = 1'b1;
        run(0, 1);
        for (int p = 0; p < 2; p++) begin   // 13-cycle period with demand
            run(1, 4); ew_service(1'b0);
        end

        sensor_ew = 1'b0;                   // no demand: NS green holds
        run(1, 10);
        sensor_ew = 1'b1;
        run(1, 1); ew_service(1'b0);

        sensor_ew = 1'b0;                   // EW ped pulse during hold
        run(1, 5);
        ped_req_ew = 1'b1; run(1, 1); ped_req_ew = 1'b0;
        run(1, 1); ew_service(1'b1);
        run(1, 6);                          // latch cleared: hold again

        ped_req_ns = 1'b1; run(1, 1); ped_req_ns = 1'b0;   // held for next NS green
        sensor_ew = 1'b1;
        run(1, 1); ew_service(1'b0);
        run(1, 4, 1'b1, 1'b0);

        run(2, 2); run(0, 1); run(3, 1);    // emergency in 2nd EW_G cycle
        emergency = 1'b1;
        run(3, 1); run(4, 2); run(0, 1); run(5, 4);
        emergency = 1'b0;
        run(5, 1); run(0, 1); run(1, 4); run(2, 1);

        reset = 1'b0;                       // async reset mid NS_Y
        run(0, 2);
        reset = 1'b1;
        run(0, 1); run(1, 4); run(2, 1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        // TICK_DIV=4 instance
        @(posedge clk); #1;
        reset4 = 1'b1;
        ovl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (NS4 !== 3'b100 && EW4 !== 3'b100) ovl = 1'b1;
            if (rph.size() == 0 || rph[rph.size()-1] != int'(phase4)) begin
                rph.push_back(int'(phase4));
                rlen.push_back(1);
            end else begin
                rlen[rlen.size()-1] = rlen[rlen.size()-1] + 1;
            end
        end
        checks++;
        if (ovl) begin
            errors++;
            $display("FAIL div4_overlap: got overlapping non-red lamps, expected none");
        end
        checks++;
        if (rph.size() < 9) begin
            errors++;
            $display("FAIL div4_runs: got %0d phase runs, expected >= 9", rph.size());
        end else begin
            exp_ph = '{0, 1, 2, 0, 3, 4, 0, 1};
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rph[i] != exp_ph[i]) begin
                    errors++;
                    $display("FAIL div4_seq%0d: got phase %0d, expected %0d", i, rph[i], exp_ph[i]);
                end
            end
            checks++;
            if (rlen[1] < 13 || rlen[1] > 16) begin
                errors++;
                $display("FAIL div4_nsg_len: got %0d, expected 13..16", rlen[1]);
            end
            checks++;
            if (rlen[4] != 12) begin
                errors++;
                $display("FAIL div4_ewg_len: got %0d, expected 12", rlen[4]);
            end
            sum = 0;
            for (int i = 2; i < 8; i++) sum += rlen[i];
            checks++;
            if (sum != 52) begin
                errors++;
                $display("FAIL div4_period: got %0d cycles, expected 52", sum);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
